// File: rtl/fp_norm_pkg.sv
// Shared constants and pipeline payload types for the 128-bit mantissa normalizer.
package fp_norm_pkg;

    localparam int MANT_W = 128;
    localparam int LZ_W   = 7;

    // Width-independent part of the S1 payload; the exponent is carried alongside.
    typedef struct packed {
        logic              sign;
        logic              zero;
        logic [LZ_W-1:0]   lz;
        logic [MANT_W-1:0] mant;
    } s1_t;

    // Flag part of the S2 payload; exponent and mantissa are carried alongside.
    typedef struct packed {
        logic sign;
        logic zero;
        logic uflow;
        logic guard;
        logic round;
        logic sticky;
    } s2_t;

endpackage

// File: rtl/fp_norm_128_if.sv
// Input/output handshake bundle of fp_norm_128; master drives inputs, slave is the normalizer.
interface fp_norm_128_if #(
    parameter int EXP_W = 10,
    parameter int OUT_W = 24
);
    import fp_norm_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;

    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [OUT_W-1:0]  out_mant;
    logic              out_guard;
    logic              out_round;
    logic              out_sticky;
    logic              out_zero;
    logic              out_uflow;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant,
               out_guard, out_round, out_sticky, out_zero, out_uflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant,
               out_guard, out_round, out_sticky, out_zero, out_uflow
    );

endinterface

// File: rtl/lzc_128.sv
// Leading-zero counter for a 128-bit word: c = zeros above the highest set bit, v = any bit set.
module lzc_128 (
    input  logic [127:0] a,
    output logic [6:0]   c,
    output logic         v
);

    // Scanning upwards lets the highest set bit be the last one to write c.
    always_comb begin
        c = '0;
        v = |a;
        for (int i = 0; i < 128; i++) begin
            if (a[i]) begin
                c = 7'(127 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_128.sv
// Two-stage normalizer: S1 registers input plus leading-zero count, S2 registers the shifted result.
// Sticky generation is built only when FP_NORM_STICKY_EN is defined.
module fp_norm_128
    import fp_norm_pkg::*;
#(
    parameter int EXP_W = 10,
    parameter int OUT_W = 24
) (
    input logic          clk,
    input logic          rst,
    fp_norm_128_if.slave bus
);

    localparam int CW = (EXP_W > LZ_W) ? EXP_W + 1 : LZ_W + 1;

    s1_t              s1;
    logic [EXP_W-1:0] s1_exp;
    logic             s1_valid;
    logic             s1_adv;

    s2_t              s2;
    logic [EXP_W-1:0] s2_exp;
    logic [OUT_W-1:0] s2_mant;
    logic             s2_valid;

    logic [LZ_W-1:0]  lz_c;
    logic             lz_v;

    logic [CW-1:0]    lz_w;
    logic [CW-1:0]    exp_w;
    logic [CW-1:0]    sh_w;
    logic [OUT_W+1:0] m_hi;
    logic             uflow_c;
    logic             sticky_c;
    logic [EXP_W-1:0] nexp;

    lzc_128 u_lzc (
        .a (bus.in_mant),
        .c (lz_c),
        .v (lz_v)
    );

    assign s1_adv       = ~s2_valid | bus.out_ready;
    assign bus.in_ready = ~s1_valid | s1_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
            s1_exp   <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1.sign <= bus.in_sign;
                s1.zero <= ~lz_v;
                s1.lz   <= lz_c;
                s1.mant <= bus.in_mant;
                s1_exp  <= bus.in_exp;
            end
        end
    end

    // Shift is clamped so a denormal result keeps exponent 1 worth of scaling.
    always_comb begin
        lz_w    = CW'(s1.lz);
        exp_w   = CW'(s1_exp);
        uflow_c = (lz_w >= exp_w) & ~s1.zero;
        if (lz_w < exp_w) begin
            sh_w = lz_w;
        end else if (exp_w == '0) begin
            sh_w = '0;
        end else begin
            sh_w = exp_w - CW'(1);
        end
        m_hi = (OUT_W+2)'((s1.mant << sh_w) >> (MANT_W - OUT_W - 2));
        nexp = EXP_W'(exp_w - sh_w);
        if (uflow_c || s1.zero) begin
            nexp = '0;
        end
    end

`ifdef FP_NORM_STICKY_EN
    assign sticky_c = |((s1.mant << sh_w) << (OUT_W + 2));
`else
    assign sticky_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2       <= '0;
            s2_exp   <= '0;
            s2_mant  <= '0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2.sign   <= s1.sign;
                s2.zero   <= s1.zero;
                s2.uflow  <= uflow_c;
                s2.guard  <= m_hi[1];
                s2.round  <= m_hi[0];
                s2.sticky <= sticky_c;
                s2_exp    <= nexp;
                s2_mant   <= m_hi[OUT_W+1:2];
            end
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_sign   = s2.sign;
    assign bus.out_exp    = s2_exp;
    assign bus.out_mant   = s2_mant;
    assign bus.out_guard  = s2.guard;
    assign bus.out_round  = s2.round;
    assign bus.out_sticky = s2.sticky;
    assign bus.out_zero   = s2.zero;
    assign bus.out_uflow  = s2.uflow;

endmodule

// File: tb/tb_fp_norm_128.sv
// Scoreboard bench for fp_norm_128: directed vectors queued at input handshake, checked by a monitor.
// Expected sticky follows FP_NORM_STICKY_EN.
module tb_fp_norm_128;

    localparam int EXP_W = 10;
    localparam int OUT_W = 24;

`ifdef FP_NORM_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [OUT_W-1:0] mant;
        logic             guard;
        logic             round;
        logic             sticky;
        logic             zero;
        logic             uflow;
    } res_t;

    typedef struct {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [127:0]     mant;
        res_t             want;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   inflight = 0;
    int   mode = 0;
    res_t expq[$];
    vec_t vecs[12];

    fp_norm_128_if #(.EXP_W(EXP_W), .OUT_W(OUT_W)) bus ();

    fp_norm_128 #(.EXP_W(EXP_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [EXP_W-1:0] e, input logic [127:0] m,
                                input logic [EXP_W-1:0] oe, input logic [OUT_W-1:0] om,
                                input logic g, input logic r, input logic st, input logic z, input logic u);
        vec_t v;
        v.sign = s;
        v.exp  = e;
        v.mant = m;
        v.want = '{sign: s, exp: oe, mant: om, guard: g, round: r, sticky: st, zero: z, uflow: u};
        return v;
    endfunction

    function automatic res_t curRes();
        return '{sign: bus.out_sign, exp: bus.out_exp, mant: bus.out_mant, guard: bus.out_guard,
                 round: bus.out_round, sticky: bus.out_sticky, zero: bus.out_zero, uflow: bus.out_uflow};
    endfunction

    // Drive one vector and hold it until accepted; the expected result is queued on acceptance.
    task automatic applyStimulus(input vec_t v);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_sign  = v.sign;
        bus.in_exp   = v.exp;
        bus.in_mant  = v.mant;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: in_ready stayed %0b, required 1", bus.in_ready);
        end else begin
            expq.push_back(v.want);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drainWait(input string tag);
        int n = 0;
        while ((expq.size() != 0 || bus.out_valid) && n < 300) begin
            n++;
            @(negedge clk);
        end
        checkOutput({tag, "_drained"}, 128'(expq.size()), 128'd0);
    endtask

    // Ready pattern generator: always ready, 1,0,0 repeating, or held low.
    initial begin : ready_gen
        int ph = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: bus.out_ready = 1'b1;
                1: begin
                    bus.out_ready = (ph % 3 == 0);
                    ph++;
                end
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: backpressure, stall hold and in-order result checks at each falling edge.
    initial begin : monitor
        res_t want;
        res_t snap;
        logic prev_stall;
        prev_stall = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                inflight   = 0;
                prev_stall = 1'b0;
            end else begin
                checkOutput("in_ready", 128'(bus.in_ready),
                            (inflight == 2 && !bus.out_ready) ? 128'd0 : 128'd1);
                if (prev_stall) begin
                    checkOutput("stall_hold", 128'({bus.out_valid, curRes()}), 128'({1'b1, snap}));
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                if (prev_stall) snap = curRes();
                if (bus.out_valid && expq.size() == 0) begin
                    checkOutput("unexpected_out", 128'(bus.out_valid), 128'd0);
                end else if (bus.out_valid && bus.out_ready) begin
                    want = expq.pop_front();
                    checkOutput("out_sign",   128'(bus.out_sign),   128'(want.sign));
                    checkOutput("out_exp",    128'(bus.out_exp),    128'(want.exp));
                    checkOutput("out_mant",   128'(bus.out_mant),   128'(want.mant));
                    checkOutput("out_guard",  128'(bus.out_guard),  128'(want.guard));
                    checkOutput("out_round",  128'(bus.out_round),  128'(want.round));
                    checkOutput("out_sticky", 128'(bus.out_sticky), 128'(want.sticky));
                    checkOutput("out_zero",   128'(bus.out_zero),   128'(want.zero));
                    checkOutput("out_uflow",  128'(bus.out_uflow),  128'(want.uflow));
                end
                inflight = inflight + ((bus.in_valid && bus.in_ready) ? 1 : 0)
                                    - ((bus.out_valid && bus.out_ready) ? 1 : 0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bus.in_valid = 1'b0;
        bus.in_sign  = 1'b0;
        bus.in_exp   = '0;
        bus.in_mant  = '0;

        //         sign exp   in_mant                                      out_exp out_mant   g     r     s     z     u
        vecs[0]  = mk(0, 50,  128'd1 << 100,                                23,  24'h800000, 0, 0, 0,   0, 0);
        vecs[1]  = mk(0, 10,  128'd1,                                       0,   24'h000000, 0, 0, STK, 0, 1);
        vecs[2]  = mk(1, 99,  128'd0,                                       0,   24'h000000, 0, 0, 0,   1, 0);
        vecs[3]  = mk(1, 5,   ~128'd0,                                      5,   24'hFFFFFF, 1, 1, STK, 0, 0);
        vecs[4]  = mk(0, 1,   (128'd1 << 127) | (128'd1 << 103) | (128'd1 << 102),
                                                                            1,   24'h800000, 1, 1, 0,   0, 0);
        vecs[5]  = mk(0, 0,   128'd1 << 127,                                0,   24'h800000, 0, 0, 0,   0, 1);
        vecs[6]  = mk(1, 7,   128'd1 << 120,                                0,   24'h400000, 0, 0, 0,   0, 1);
        vecs[7]  = mk(0, 8,   128'd1 << 120,                                1,   24'h800000, 0, 0, 0,   0, 0);
        vecs[8]  = mk(0, 100, (128'd1 << 110) | 128'd1,                     83,  24'h800000, 0, 0, STK, 0, 0);
        vecs[9]  = mk(1, 200, 128'hABCDEF << 80,                            176, 24'hABCDEF, 0, 0, 0,   0, 0);
        vecs[10] = mk(0, 300, 128'hABCDEF7 << 60,                           260, 24'hABCDEF, 0, 1, STK, 0, 0);
        vecs[11] = mk(0, 0,   128'd0,                                       0,   24'h000000, 0, 0, 0,   1, 0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 128'(bus.out_valid), 128'd0);
        checkOutput("reset_out_data",  128'(curRes()), 128'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 128'(bus.in_ready), 128'd1);
        @(posedge clk);
        #1;

        $display("[TB] directed vectors, sink always ready");
        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
        drainWait("directed");

        $display("[TB] 8 back-to-back items, ready pattern 1,0,0");
        mode = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);
        drainWait("stall");

        $display("[TB] reset with two items in flight");
        mode = 2;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(vecs[0]);
        applyStimulus(vecs[3]);
        @(negedge clk);
        checkOutput("full_out_valid", 128'(bus.out_valid), 128'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", 128'(bus.out_valid), 128'd0);
        checkOutput("async_rst_out_data",  128'(curRes()), 128'd0);
        expq.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mode = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stale_out_valid", 128'(bus.out_valid), 128'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(vecs[9]);
        @(negedge clk);
        checkOutput("latency_early", 128'(bus.out_valid), 128'd0);
        @(negedge clk);
        checkOutput("latency_two", 128'(bus.out_valid), 128'd1);
        drainWait("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_norm_128.md
FP_NORM_128 -- requirements
Module: fp_norm_128

Interface
REQ-001 SHALL have parameter EXP_W, default 10, meaning exponent field width (unsigned, biased).
REQ-002 SHALL have parameter OUT_W, default 24, meaning normalized mantissa output width (2..125).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  and in_ready  output  1 (input handshake).
REQ-006 SHALL have ports in_sign  input  1, in_exp  input  EXP_W, in_mant  input  128 (unnormalized mantissa, bit127 = MSB weight).
REQ-007 SHALL have port out_valid  output  1  and out_ready  input  1 (output handshake).
REQ-008 SHALL have ports out_sign  output  1, out_exp  output  EXP_W, out_mant  output  OUT_W.
REQ-009 SHALL have ports out_guard, out_round, out_sticky, out_zero, out_uflow  output  1 each.

Function
REQ-010 SHALL be a 2-stage pipeline: S1 registers the input and its leading-zero count lz (0..127) plus the all-zero flag; S2 registers the shifted result.
REQ-011 SHALL transfer on a handshake only when valid and ready are both 1 in the same cycle.
REQ-012 SHALL drive in_ready = ~s1_valid | s1_adv, where s1_adv = ~s2_valid | out_ready; throughput one item per cycle; latency 2 cycles when unstalled.
REQ-013 SHALL hold all out_* stable while out_valid=1 and out_ready=0; no data lost or duplicated under any stall pattern.
REQ-014 SHALL compute shift amount sh = lz when lz < in_exp, else sh = in_exp - 1 saturated at 0 (denormal clamp), out_uflow = (lz >= in_exp) and not zero.
REQ-015 SHALL produce out_exp = in_exp - sh when no underflow, else 0.
REQ-016 SHALL form m = in_mant << sh (128 bits, zero fill); out_mant = m[127:128-OUT_W]; out_guard = m[127-OUT_W]; out_round = m[126-OUT_W].
REQ-017 SHALL set out_sticky = OR of m[125-OUT_W:0] (subject to REQ-022).
REQ-018 SHALL, when in_mant = 0, set out_zero=1, out_exp=0, out_mant=0, guard/round/sticky=0, out_uflow=0; out_sign passes through.
REQ-019 SHALL pass in_sign to out_sign unchanged.

Reset
REQ-020 SHALL, on rst=1, asynchronously clear s1_valid, s2_valid, out_valid and all out_* data to 0; in_ready reads 1 from the first cycle after rst deasserts.
REQ-021 SHALL discard any in-flight items when rst asserts mid-operation; no output follows reset until a new input handshake.

Configuration
REQ-022 SHALL compile sticky logic only when macro FP_NORM_STICKY_EN is defined; without it out_sticky is constant 0 and the 126-OUT_W-bit OR-reduction is absent.

Structure
REQ-023 SHALL place shared constants (MANT_W=128, LZ_W=7) and the S1/S2 payload struct typedefs in package fp_norm_pkg.
REQ-024 SHALL instantiate the existing lzc_128 module (a[127:0], c[6:0], v) in S1 for lz and all-zero (~v) detection; no other sub-modules.

Verification
REQ-025 SHALL cover: in_mant=1<<100, in_exp=50, OUT_W=24 -> after 2 cycles out_exp=23, out_mant=0x800000, guard=round=sticky=0, zero=0.
REQ-026 SHALL cover: in_mant=128'h1 (lz=127), in_exp=10 -> sh=9, out_uflow=1, out_exp=0, out_mant=0, sticky=1 with FP_NORM_STICKY_EN, 0 without.
REQ-027 SHALL cover: in_mant=0, in_sign=1, in_exp=99 -> out_zero=1, out_exp=0, out_mant=0, out_sign=1.
REQ-028 SHALL cover: 8 back-to-back inputs with out_ready toggling 1,0,0,1,... -> all 8 outputs in order, in_ready drops only when both stages full, outputs stable during stall.
REQ-029 SHALL cover: rst asserted while 2 items in flight -> out_valid=0 immediately, no stale output after rst deasserts, next input emerges 2 cycles after its handshake.
